// File: rtl/softmax_pkg.sv
// softmax_pkg: shared defaults and state type for the softmax sequencer.
// Optional feature macro used by the sequencer: SOFTMAX_ABORT_EN.
package softmax_pkg;

  localparam int SM_TOTAL_WORDS         = 1024;
  localparam int SM_ADDR_WIDTH          = 10;
  localparam int SM_RD_LATENCY          = 1;
  localparam int SM_EXPONENT_LATENCY    = 23;
  localparam int SM_ACC_LATENCY         = 11;
  localparam int SM_RECIPROCAL_LATENCY  = 15;
  localparam int SM_MULTIPLIER_LATENCY  = 7;

  // Width of the shared wait counter used between passes; comfortably
  // larger than any sum of stage latencies we expect to configure.
  localparam int SM_CNT_WIDTH           = 16;

  typedef enum logic [2:0] {
    SM_IDLE   = 3'd0,
    SM_PASS1  = 3'd1,
    SM_DRAIN1 = 3'd2,
    SM_RECIP  = 3'd3,
    SM_PASS2  = 3'd4,
    SM_DRAIN2 = 3'd5,
    SM_DONE   = 3'd6
  } sm_state_t;

endpackage

// File: rtl/sm_delay_line.sv
// sm_delay_line: fixed-latency shift register used to align strobe groups
// with the FP stage latencies. Synchronous reset and a synchronous flush
// both clear every stage. DEPTH=0 collapses to a plain wire.
module sm_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = i_clk ^ i_rst ^ i_flush;
      assign o_data   = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      // Shift the token one stage per cycle; reset or flush empties the line.
      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_data = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl: two-pass sequencer for the exp -> acc -> reciprocal -> mul
// softmax datapath. Pass 1 streams the vector through exp into the
// accumulator, pass 2 re-reads it into the multiplier and writes results.
// Optional feature macro: SOFTMAX_ABORT_EN adds i_abort / o_aborted.
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int TOTAL_WORDS        = SM_TOTAL_WORDS,
  parameter int ADDR_WIDTH         = SM_ADDR_WIDTH,
  parameter int RD_LATENCY         = SM_RD_LATENCY,
  parameter int EXPONENT_LATENCY   = SM_EXPONENT_LATENCY,
  parameter int ACC_LATENCY        = SM_ACC_LATENCY,
  parameter int RECIPROCAL_LATENCY = SM_RECIPROCAL_LATENCY,
  parameter int MULTIPLIER_LATENCY = SM_MULTIPLIER_LATENCY
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_vec_len,
`ifdef SOFTMAX_ABORT_EN
  input  logic                  i_abort,
  output logic                  o_aborted,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_len_err,
  output logic                  o_buf_rd_en,
  output logic [ADDR_WIDTH-1:0] o_buf_rd_addr,
  output logic                  o_exp_in_valid,
  output logic                  o_acc_clear,
  output logic                  o_acc_in_valid,
  output logic                  o_acc_last,
  output logic                  o_recip_start,
  output logic                  o_mul_in_valid,
  output logic                  o_out_wr_en,
  output logic [ADDR_WIDTH-1:0] o_out_wr_addr
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam int CNT_W = SM_CNT_WIDTH;

  // Wait-counter load values. A value N loaded at the end of cycle c makes
  // the counter reach 1 in cycle c+N, and the registered event then appears
  // in cycle c+N+1.
  localparam logic [CNT_W-1:0] DRAIN1_LOAD =
    CNT_W'(RD_LATENCY + EXPONENT_LATENCY + ACC_LATENCY - 1);
  localparam logic [CNT_W-1:0] RECIP_LOAD  = CNT_W'(RECIPROCAL_LATENCY);
  localparam logic [CNT_W-1:0] DRAIN2_LOAD =
    CNT_W'(RD_LATENCY + MULTIPLIER_LATENCY);

  sm_state_t             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_last_addr, w_last_addr_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic                  r_rd_last, w_rd_last_nxt;
  logic                  r_acc_clear, w_acc_clear_nxt;
  logic                  r_recip_start, w_recip_start_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_len_err, w_len_err_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_flush;
`ifdef SOFTMAX_ABORT_EN
  logic                  r_aborted, w_aborted_nxt;
`endif

  logic                  w_len_ok;
  logic [ADDR_WIDTH-1:0] w_len_m1;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic                  w_at_last;
  logic                  w_rd_pass1;
  logic                  w_rd_pass2;

  logic [1:0]            w_exp_in, w_exp_out;
  logic [1:0]            w_acc_out;
  logic [ADDR_WIDTH:0]   w_mul_in, w_mul_out;
  logic [ADDR_WIDTH:0]   w_wr_out;

  assign w_len_ok   = (i_vec_len != '0) && (i_vec_len <= LEN_W'(TOTAL_WORDS));
  assign w_len_m1   = ADDR_WIDTH'(i_vec_len - LEN_W'(1));
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
  assign w_at_last  = (r_addr == r_last_addr);
  assign w_rd_pass1 = r_rd_en && (r_state == SM_PASS1);
  assign w_rd_pass2 = r_rd_en && (r_state == SM_PASS2);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SM_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-output decode; the read address only ever counts up
  // to the stored last address, so it cannot wrap even at full depth.
  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_last_addr_nxt   = r_last_addr;
    w_cnt_nxt         = r_cnt;
    w_rd_en_nxt       = 1'b0;
    w_rd_last_nxt     = 1'b0;
    w_acc_clear_nxt   = 1'b0;
    w_recip_start_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    w_len_err_nxt     = 1'b0;
    w_busy_nxt        = r_busy;
    w_flush           = 1'b0;
`ifdef SOFTMAX_ABORT_EN
    w_aborted_nxt     = 1'b0;
`endif

    case (r_state)
      SM_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_start) begin
          if (w_len_ok) begin
            w_state_nxt     = SM_PASS1;
            w_last_addr_nxt = w_len_m1;
            w_addr_nxt      = '0;
            w_rd_en_nxt     = 1'b1;
            w_rd_last_nxt   = (w_len_m1 == '0);
            w_acc_clear_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
          end else begin
            w_len_err_nxt   = 1'b1;
          end
        end
      end

      SM_PASS1, SM_PASS2: begin
        if (w_at_last) begin
          w_addr_nxt = '0;
          if (r_state == SM_PASS1) begin
            w_state_nxt = SM_DRAIN1;
            w_cnt_nxt   = DRAIN1_LOAD;
          end else begin
            w_state_nxt = SM_DRAIN2;
            w_cnt_nxt   = DRAIN2_LOAD;
          end
        end else begin
          w_rd_en_nxt   = 1'b1;
          w_addr_nxt    = w_addr_inc;
          w_rd_last_nxt = (w_addr_inc == r_last_addr);
        end
      end

      SM_DRAIN1: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt       = SM_RECIP;
          w_recip_start_nxt = 1'b1;
          w_cnt_nxt         = RECIP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      SM_RECIP: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt   = SM_PASS2;
          w_addr_nxt    = '0;
          w_rd_en_nxt   = 1'b1;
          w_rd_last_nxt = (r_last_addr == '0);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      SM_DRAIN2: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = SM_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      SM_DONE: begin
        w_state_nxt = SM_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = SM_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

`ifdef SOFTMAX_ABORT_EN
    if (i_abort && (r_state != SM_IDLE)) begin
      w_state_nxt       = SM_IDLE;
      w_addr_nxt        = '0;
      w_cnt_nxt         = '0;
      w_rd_en_nxt       = 1'b0;
      w_rd_last_nxt     = 1'b0;
      w_acc_clear_nxt   = 1'b0;
      w_recip_start_nxt = 1'b0;
      w_done_nxt        = 1'b0;
      w_busy_nxt        = 1'b0;
      w_flush           = 1'b1;
      w_aborted_nxt     = 1'b1;
    end
`endif
  end

  // Registered control outputs and sequencing counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr        <= '0;
      r_last_addr   <= '0;
      r_cnt         <= '0;
      r_rd_en       <= 1'b0;
      r_rd_last     <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_recip_start <= 1'b0;
      r_done        <= 1'b0;
      r_len_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_addr        <= w_addr_nxt;
      r_last_addr   <= w_last_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rd_en       <= w_rd_en_nxt;
      r_rd_last     <= w_rd_last_nxt;
      r_acc_clear   <= w_acc_clear_nxt;
      r_recip_start <= w_recip_start_nxt;
      r_done        <= w_done_nxt;
      r_len_err     <= w_len_err_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

`ifdef SOFTMAX_ABORT_EN
  // One-cycle pulse acknowledging an abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_aborted <= 1'b0;
    else       r_aborted <= w_aborted_nxt;
  end
  assign o_aborted = r_aborted;
`endif

  // Only pass-1 reads feed the exp unit; the last-token flag rides along so
  // the accumulator sees it on the final operand.
  assign w_exp_in = {r_rd_last & w_rd_pass1, w_rd_pass1};

  sm_delay_line #(.DEPTH(RD_LATENCY), .WIDTH(2)) u_exp_line (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(w_flush),
    .i_data (w_exp_in),
    .o_data (w_exp_out)
  );

  sm_delay_line #(.DEPTH(EXPONENT_LATENCY), .WIDTH(2)) u_acc_line (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(w_flush),
    .i_data (w_exp_out),
    .o_data (w_acc_out)
  );

  // Pass-2 reads carry their address so the write lands at the same index;
  // the address is zeroed when idle so quiet cycles show no stale value.
  assign w_mul_in = {w_rd_pass2, r_addr & {ADDR_WIDTH{w_rd_pass2}}};

  sm_delay_line #(.DEPTH(RD_LATENCY), .WIDTH(ADDR_WIDTH + 1)) u_mul_line (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(w_flush),
    .i_data (w_mul_in),
    .o_data (w_mul_out)
  );

  sm_delay_line #(.DEPTH(MULTIPLIER_LATENCY), .WIDTH(ADDR_WIDTH + 1)) u_wr_line (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(w_flush),
    .i_data (w_mul_out),
    .o_data (w_wr_out)
  );

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_len_err      = r_len_err;
  assign o_buf_rd_en    = r_rd_en;
  assign o_buf_rd_addr  = r_addr;
  assign o_exp_in_valid = w_exp_out[0];
  assign o_acc_clear    = r_acc_clear;
  assign o_acc_in_valid = w_acc_out[0];
  assign o_acc_last     = w_acc_out[1];
  assign o_recip_start  = r_recip_start;
  assign o_mul_in_valid = w_mul_out[ADDR_WIDTH];
  assign o_out_wr_en    = w_wr_out[ADDR_WIDTH];
  assign o_out_wr_addr  = w_wr_out[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl: scoreboard bench for softmax_seq_ctrl.
// Stimulus pushes expected strobe events (cycle, address) into per-strobe
// queues; a negedge monitor pops and compares whenever a strobe is seen.
// Optional feature macro exercised when defined: SOFTMAX_ABORT_EN.
module tb_softmax_seq_ctrl;

  localparam int AW   = 10;
  localparam int RDL  = 1;
  localparam int EXPL = 23;
  localparam int ACCL = 11;
  localparam int RCPL = 15;
  localparam int MULL = 7;

  localparam int K_CLEAR   = 0;
  localparam int K_RD      = 1;
  localparam int K_EXP     = 2;
  localparam int K_ACC     = 3;
  localparam int K_LAST    = 4;
  localparam int K_RECIP   = 5;
  localparam int K_MUL     = 6;
  localparam int K_WR      = 7;
  localparam int K_DONE    = 8;
  localparam int K_LERR    = 9;
  localparam int K_ABORTED = 10;
  localparam int NK        = 11;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   vecLen;
  logic          abortIn;
  logic          abortedOut;
  logic          o_busy, o_done, o_len_err, o_buf_rd_en;
  logic [AW-1:0] o_buf_rd_addr;
  logic          o_exp_in_valid, o_acc_clear, o_acc_in_valid, o_acc_last;
  logic          o_recip_start, o_mul_in_valid, o_out_wr_en;
  logic [AW-1:0] o_out_wr_addr;

  int cycQ  [NK][$];
  int addrQ [NK][$];
  string kname [NK];
  logic [NK-1:0] obs;

  int checks;
  int failures;
  int cyc;
  int busyStart;
  int busyEnd;
  int tRun;
  int ec;
  int ea;
  bit monOn;

  softmax_seq_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_vec_len     (vecLen),
`ifdef SOFTMAX_ABORT_EN
    .i_abort       (abortIn),
    .o_aborted     (abortedOut),
`endif
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_len_err     (o_len_err),
    .o_buf_rd_en   (o_buf_rd_en),
    .o_buf_rd_addr (o_buf_rd_addr),
    .o_exp_in_valid(o_exp_in_valid),
    .o_acc_clear   (o_acc_clear),
    .o_acc_in_valid(o_acc_in_valid),
    .o_acc_last    (o_acc_last),
    .o_recip_start (o_recip_start),
    .o_mul_in_valid(o_mul_in_valid),
    .o_out_wr_en   (o_out_wr_en),
    .o_out_wr_addr (o_out_wr_addr)
  );

`ifndef SOFTMAX_ABORT_EN
  assign abortedOut = 1'b0;
`endif

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the schedule ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before cycle 30000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectEvent(input int k, input int c, input int a);
    cycQ[k].push_back(c);
    addrQ[k].push_back(a);
  endtask

  task automatic flushExpect();
    for (int k = 0; k < NK; k++) begin
      cycQ[k].delete();
      addrQ[k].delete();
    end
  endtask

  function automatic longint allOut();
    return longint'({o_busy, o_done, o_len_err, o_buf_rd_en, o_buf_rd_addr,
                     o_exp_in_valid, o_acc_clear, o_acc_in_valid, o_acc_last,
                     o_recip_start, o_mul_in_valid, o_out_wr_en, o_out_wr_addr});
  endfunction

  task automatic waitCyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one start in the current cycle and queue the expected schedule.
  task automatic applyStimulus(input int len, output int t);
    int recip;
    int p2;
    t      = cyc;
    start  = 1'b1;
    vecLen = (AW+1)'(len);
    if (len >= 1 && len <= 1024) begin
      recip = t + len + RDL + EXPL + ACCL;
      p2    = recip + RCPL;
      expectEvent(K_CLEAR, t + 1, 0);
      for (int i = 0; i < len; i++) begin
        expectEvent(K_RD,  t + 1 + i, i);
        expectEvent(K_EXP, t + 1 + RDL + i, 0);
        expectEvent(K_ACC, t + 1 + RDL + EXPL + i, 0);
      end
      expectEvent(K_LAST, t + RDL + EXPL + len, 0);
      expectEvent(K_RECIP, recip, 0);
      for (int i = 0; i < len; i++) begin
        expectEvent(K_RD,  p2 + i, i);
        expectEvent(K_MUL, p2 + RDL + i, 0);
        expectEvent(K_WR,  p2 + RDL + MULL + i, i);
      end
      expectEvent(K_DONE, p2 + len + RDL + MULL, 0);
      busyStart = t + 1;
      busyEnd   = p2 + len + RDL + MULL;
    end else begin
      expectEvent(K_LERR, t + 1, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Monitor: pop and compare every strobe the DUT presents.
  always @(negedge clk) begin
    if (monOn) begin
      obs[K_CLEAR]   = o_acc_clear;
      obs[K_RD]      = o_buf_rd_en;
      obs[K_EXP]     = o_exp_in_valid;
      obs[K_ACC]     = o_acc_in_valid;
      obs[K_LAST]    = o_acc_last;
      obs[K_RECIP]   = o_recip_start;
      obs[K_MUL]     = o_mul_in_valid;
      obs[K_WR]      = o_out_wr_en;
      obs[K_DONE]    = o_done;
      obs[K_LERR]    = o_len_err;
      obs[K_ABORTED] = abortedOut;
      for (int k = 0; k < NK; k++) begin
        while (cycQ[k].size() > 0 && cycQ[k][0] < cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s missing: got no strobe by cycle %0d, expected at cycle %0d",
                   kname[k], cyc, cycQ[k][0]);
          void'(cycQ[k].pop_front());
          void'(addrQ[k].pop_front());
        end
        if (obs[k]) begin
          if (cycQ[k].size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s unexpected: got strobe at cycle %0d, expected none", kname[k], cyc);
          end else begin
            ec = cycQ[k].pop_front();
            ea = addrQ[k].pop_front();
            checkOutput({kname[k], "_cycle"}, cyc, ec);
            if (k == K_RD) checkOutput("rd_addr", o_buf_rd_addr, ea);
            if (k == K_WR) checkOutput("wr_addr", o_out_wr_addr, ea);
          end
        end
      end
      checkOutput("busy", o_busy, (cyc >= busyStart && cyc <= busyEnd));
    end
  end

  // Directed sequence.
  initial begin
    kname[K_CLEAR]   = "acc_clear";
    kname[K_RD]      = "buf_rd_en";
    kname[K_EXP]     = "exp_in_valid";
    kname[K_ACC]     = "acc_in_valid";
    kname[K_LAST]    = "acc_last";
    kname[K_RECIP]   = "recip_start";
    kname[K_MUL]     = "mul_in_valid";
    kname[K_WR]      = "out_wr_en";
    kname[K_DONE]    = "done";
    kname[K_LERR]    = "len_err";
    kname[K_ABORTED] = "aborted";
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    monOn     = 1'b0;
    busyStart = 1;
    busyEnd   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    vecLen    = '0;
    abortIn   = 1'b0;

    @(posedge clk);
    #1;
    monOn = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset_outputs", allOut(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] L=10 run with a stray start during pass 2");
    applyStimulus(10, tRun);
    waitCyc(tRun + 65);
    start  = 1'b1;
    vecLen = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;

    $display("[TB] L=1 run started the cycle after done");
    waitCyc(tRun + 79);
    applyStimulus(1, tRun);
    waitCyc(tRun + 63);

    $display("[TB] rejected lengths 0 and 1025");
    applyStimulus(0, tRun);
    waitCyc(tRun + 4);
    applyStimulus(1025, tRun);
    waitCyc(tRun + 4);

    $display("[TB] reset during drain 1, then L=4 run");
    applyStimulus(10, tRun);
    waitCyc(tRun + 30);
    rst = 1'b1;
    @(negedge clk);
    #1;
    flushExpect();
    busyEnd = tRun + 30;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_reset_outputs", allOut(), 0);
    waitCyc(tRun + 33);
    applyStimulus(4, tRun);
    waitCyc(tRun + 2 * 4 + 61);

`ifdef SOFTMAX_ABORT_EN
    $display("[TB] L=1024 run aborted in pass 1");
    applyStimulus(1024, tRun);
    waitCyc(tRun + 50);
    abortIn = 1'b1;
    @(negedge clk);
    #1;
    flushExpect();
    busyEnd = tRun + 50;
    expectEvent(K_ABORTED, tRun + 51, 0);
    @(posedge clk);
    #1;
    abortIn = 1'b0;
    checkOutput("post_abort_outputs", allOut(), 0);
    waitCyc(tRun + 55);
`endif

    $display("[TB] L=1024 full-depth run");
    applyStimulus(1024, tRun);
    waitCyc(tRun + 2 * 1024 + 61);

    for (int k = 0; k < NK; k++) begin
      checkOutput({"pending_", kname[k]}, cycQ[k].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
